// File: rtl/avr_fetch_if.sv
// Fetch-unit bus: FLASH read port, core redirect and the instruction valid/ready handshake.
// master = fetch unit side, slave = core/FLASH side.
interface avr_fetch_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] flash_addr;
  logic              flash_rd_en;
  logic [15:0]       flash_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr_word1;
  logic [15:0]       instr_word2;
  logic              instr_is32;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output flash_addr, flash_rd_en,
    input  flash_data,
    input  redirect, redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr_word1, instr_word2, instr_is32, instr_pc
  );

  modport slave (
    input  flash_addr, flash_rd_en,
    output flash_data,
    output redirect, redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr_word1, instr_word2, instr_is32, instr_pc
  );
endinterface

// File: rtl/avr_fetch_unit.sv
// AVR instruction fetch: FLASH prefetch queue, byte swap, 32-bit opcode pairing, redirect.
// Optional macro FETCH_BYPASS_EN presents a single-word response directly when the queue is empty.
module avr_fetch_unit #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 4
) (
  input logic         clk,
  input logic         rst,
  avr_fetch_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  // jmp/call and lds/sts carry a second opcode word
  function automatic logic is_long(input logic [15:0] w);
    return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
  endfunction

  logic [15:0]       q_word [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];

  ptr_t              rd_ptr_q, wr_ptr_q;
  cnt_t              count_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;

  logic [15:0] resp_word;
  logic [15:0] head_word, tail_word;
  logic        head_long;
  logic        issue;
  logic        bypass;
  logic        fire;
  logic        push;
  logic [1:0]  pop_n;

  assign resp_word = {bus.flash_data[7:0], bus.flash_data[15:8]};
  assign head_word = q_word[rd_ptr_q];
  assign tail_word = q_word[rd_ptr_q + ptr_t'(1)];
  assign head_long = is_long(head_word);

  assign issue = !rst && !bus.redirect && ((32'(count_q) + 32'(inflight_q)) < DEPTH);
  assign bus.flash_rd_en = issue;
  assign bus.flash_addr  = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
  assign bypass = (count_q == '0) && inflight_q && !is_long(resp_word);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    bus.instr_valid = 1'b0;
    bus.instr_word1 = 16'h0000;
    bus.instr_word2 = 16'h0000;
    bus.instr_is32  = 1'b0;
    bus.instr_pc    = '0;
    if (!rst) begin
      if (bypass) begin
        bus.instr_valid = 1'b1;
        bus.instr_word1 = resp_word;
        bus.instr_pc    = inflight_pc_q;
      end else if (count_q != '0) begin
        bus.instr_word1 = head_word;
        bus.instr_pc    = q_pc[rd_ptr_q];
        bus.instr_is32  = head_long;
        // a long opcode waits until its second word has landed
        bus.instr_valid = !head_long || (count_q >= cnt_t'(2));
        if (head_long && (count_q >= cnt_t'(2))) begin
          bus.instr_word2 = tail_word;
        end
      end
    end
  end

  always_comb begin
    fire  = bus.instr_valid && bus.instr_ready && !bus.redirect && !rst;
    pop_n = 2'd0;
    if (fire && !bypass) begin
      pop_n = head_long ? 2'd2 : 2'd1;
    end
    push = inflight_q && !(bypass && fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (bus.redirect) begin
      // flush; clearing inflight_q discards the response arriving next cycle
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= bus.redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      rd_ptr_q   <= rd_ptr_q + ptr_t'(pop_n);
      count_q    <= count_q + cnt_t'(push) - cnt_t'(pop_n);
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect && push) begin
      q_word[wr_ptr_q] <= resp_word;
      q_pc[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_avr_fetch_unit.sv
// Bench for avr_fetch_unit: directed latency/redirect/wrap cases, then random traffic against
// an instruction-stream model (expected PC, opcode words, fetch-ahead bound).
module tb_avr_fetch_unit;
  localparam int AW       = 14;
  localparam int DEPTH    = 4;
  localparam int MemWords = 1 << AW;
`ifdef FETCH_BYPASS_EN
  localparam int Lat = 1;
`else
  localparam int Lat = 2;
`endif

  logic clk;
  logic rst;
  logic [15:0] mem [0:MemWords-1];
  int checks = 0;
  int errors = 0;

  avr_fetch_if #(.ADDR_W(AW)) bus ();

  avr_fetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.flash_rd_en) bus.flash_data <= mem[bus.flash_addr];
  end

  function automatic logic [15:0] sw(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic bit long_op(input logic [15:0] w);
    return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 7))
      0:       return sw((r & ~16'hFE0C) | 16'h940C);
      1:       return sw((r & ~16'hFC0F) | 16'h9000);
      default: return r;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.instr_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_valid: instr_valid=0 for 32 cycles, expected 1");
  endtask

  // Model: next instruction PC, next fetch address, words fetched but not yet consumed.
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_fetch = '0;
  int            m_ahead = 0;
  bit            m_hold = 1'b0;

  always @(negedge clk) begin
    logic [15:0] w1, w2;
    logic [AW-1:0] pc2;
    bit l, exp_issue;
    int used;
    pc2 = m_pc + 14'd1;
    w1  = sw(mem[m_pc]);
    l   = long_op(w1);
    w2  = l ? sw(mem[pc2]) : 16'h0000;
    exp_issue = !bus.redirect && (m_ahead < DEPTH);
    if (rst) begin
      chk("rst_valid", 32'(bus.instr_valid), 0);
      chk("rst_rd_en", 32'(bus.flash_rd_en), 0);
      chk("rst_word1", 32'(bus.instr_word1), 0);
      chk("rst_word2", 32'(bus.instr_word2), 0);
      chk("rst_is32", 32'(bus.instr_is32), 0);
      chk("rst_pc", 32'(bus.instr_pc), 0);
    end else begin
      chk("rd_en", 32'(bus.flash_rd_en), 32'(exp_issue));
      chk("flash_addr", 32'(bus.flash_addr), 32'(m_fetch));
      if (m_hold) chk("hold_valid", 32'(bus.instr_valid), 1);
      if (bus.instr_valid) begin
        chk("instr_pc", 32'(bus.instr_pc), 32'(m_pc));
        chk("instr_word1", 32'(bus.instr_word1), 32'(w1));
        chk("instr_is32", 32'(bus.instr_is32), 32'(l));
        chk("instr_word2", 32'(bus.instr_word2), 32'(w2));
      end
    end
    m_hold = !rst && !bus.redirect && bus.instr_valid && !bus.instr_ready;
    if (rst) begin
      m_pc = '0; m_fetch = '0; m_ahead = 0;
    end else if (bus.redirect) begin
      m_pc = bus.redirect_pc; m_fetch = bus.redirect_pc; m_ahead = 0;
    end else begin
      used = (bus.instr_valid && bus.instr_ready) ? (l ? 2 : 1) : 0;
      m_pc = m_pc + 14'(used);
      if (exp_issue) m_fetch = m_fetch + 14'd1;
      m_ahead = m_ahead + int'(exp_issue) - used;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < MemWords; i++) mem[i] = rand_word();
    mem[0] = 16'h0FEF;
    rst = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.flash_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // first issue, then latency to first valid
    @(negedge clk);
    chk("t1_first_issue", 32'(bus.flash_rd_en), 1);
    chk("t1_first_addr", 32'(bus.flash_addr), 0);
    for (int c = 1; c < Lat; c++) begin
      @(negedge clk);
      chk("t1_early_valid", 32'(bus.instr_valid), 0);
    end
    @(negedge clk);
    chk("t1_valid", 32'(bus.instr_valid), 1);
    chk("t1_word1", 32'(bus.instr_word1), 32'h0000EF0F);
    chk("t1_pc", 32'(bus.instr_pc), 0);
    chk("t1_is32", 32'(bus.instr_is32), 0);

    // jmp 0x34 pairing
    @(posedge clk); #1 rst = 1'b1;
    mem[0] = 16'h0C94; mem[1] = 16'h3400;
    @(posedge clk); #1 rst = 1'b0;
    wait_valid();
    chk("t2_is32", 32'(bus.instr_is32), 1);
    chk("t2_word1", 32'(bus.instr_word1), 32'h0000940C);
    chk("t2_word2", 32'(bus.instr_word2), 32'h00000034);
    chk("t2_pc", 32'(bus.instr_pc), 0);
    wait_valid();
    chk("t2_next_pc", 32'(bus.instr_pc), 2);

    // stall: exactly DEPTH reads
    @(posedge clk); #1 rst = 1'b1;
    bus.instr_ready = 1'b0; mem[0] = 16'h1234;
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.flash_rd_en) n++;
    end
    chk("t3_reads", 32'(n), DEPTH);
    chk("t3_rd_en_full", 32'(bus.flash_rd_en), 0);
    @(posedge clk); #1 bus.instr_ready = 1'b1;
    @(posedge clk); #1 bus.instr_ready = 1'b0;
    @(negedge clk);
    chk("t3_resume", 32'(bus.flash_rd_en), 1);

    // redirect with a read in flight and a nearly full queue
    @(posedge clk); #1 bus.redirect = 1'b1; bus.redirect_pc = 14'h0100;
    @(posedge clk); #1 bus.redirect = 1'b0; bus.instr_ready = 1'b1;
    wait_valid();
    chk("t4_pc", 32'(bus.instr_pc), 32'h100);

    // redirect to last address: fetch wraps
    @(posedge clk); #1 bus.instr_ready = 1'b0;
    mem[14'h3FFF] = 16'h1122;
    bus.redirect = 1'b1; bus.redirect_pc = 14'h3FFF;
    @(posedge clk); #1 bus.redirect = 1'b0;
    @(negedge clk);
    chk("t5_issue_a", 32'(bus.flash_rd_en), 1);
    chk("t5_addr_a", 32'(bus.flash_addr), 32'h3FFF);
    @(negedge clk);
    chk("t5_issue_b", 32'(bus.flash_rd_en), 1);
    chk("t5_addr_b", 32'(bus.flash_addr), 0);
    wait_valid();
    chk("t5_pc_a", 32'(bus.instr_pc), 32'h3FFF);
    @(posedge clk); #1 bus.instr_ready = 1'b1;
    @(negedge clk);
    wait_valid();
    chk("t5_pc_b", 32'(bus.instr_pc), 0);

    // long opcode straddling the wrap
    @(posedge clk); #1 bus.instr_ready = 1'b0;
    mem[14'h3FFF] = 16'h0E94;
    bus.redirect = 1'b1; bus.redirect_pc = 14'h3FFF;
    @(posedge clk); #1 bus.redirect = 1'b0;
    wait_valid();
    chk("t6_is32", 32'(bus.instr_is32), 1);
    chk("t6_word1", 32'(bus.instr_word1), 32'h0000940E);
    chk("t6_word2", 32'(bus.instr_word2), 32'h00003412);
    chk("t6_pc", 32'(bus.instr_pc), 32'h3FFF);
    @(posedge clk); #1 bus.instr_ready = 1'b1;

    // reset mid-stream
    wait_valid();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t7_valid_in_rst", 32'(bus.instr_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t7_valid_after", 32'(bus.instr_valid), 0);
    chk("t7_addr_after", 32'(bus.flash_addr), 0);
    chk("t7_issue_after", 32'(bus.flash_rd_en), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      bus.redirect = ($urandom_range(0, 39) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 14'h3FFE : 14'($urandom);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.redirect = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avr_fetch_unit.md
Name: avr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the MCU execute/decode block.
- Streams words from the synchronous program FLASH into a small prefetch queue and byte-swaps each word into AVR opcode order.
- Presents one instruction per valid/ready handshake, pairing both words of 32-bit opcodes (jmp, call, lds, sts).
- Accepts a redirect from the core on jumps, calls, returns and taken branches.

Parameters:
- ADDR_W, 14, word address width of FLASH and PC.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- flash_addr  output  ADDR_W  word address to FLASH; equals internal fetch_pc.
- flash_rd_en  output  1  read issued this cycle; data returns next cycle.
- flash_data  input  16  raw FLASH word, valid the cycle after a read is issued.
- redirect  input  1  core requests fetch from a new PC.
- redirect_pc  input  ADDR_W  target word address.
- instr_valid  output  1  instruction at queue head is complete.
- instr_ready  input  1  core accepts the instruction.
- instr_word1  output  16  first word, byte-swapped, i.e. {raw[7:0],raw[15:8]}.
- instr_word2  output  16  second word when instr_is32, else 16'h0000.
- instr_is32  output  1  head instruction is two words.
- instr_pc  output  ADDR_W  word address of instr_word1.

Behaviour:
- Reset: fetch_pc=0, queue empty, in-flight flag clear, instr_valid=0, instr_word1/word2=0, instr_is32=0, instr_pc=0, flash_rd_en=0 while rst high.
- Issue rule: flash_rd_en = !rst && !redirect && (count + inflight < DEPTH). On issue, fetch_pc increments and wraps 2^ADDR_W-1 -> 0.
- Response: cycle after an issue, flash_data is byte-swapped and written into the queue tagged with its PC.
- Latency: first cycle after rst falls issues addr 0; data is captured at the end of the next cycle; instr_valid rises the cycle after that, 2 cycles after the issue.
- 32-bit detect, on swapped word w:
  - (w & 16'hFE0C)==16'h940C for jmp/call;
  - (w & 16'hFC0F)==16'h9000 for lds/sts.
- Valid: instr_valid=1 when the queue holds the head word and, if it is 32-bit, also the following word. A 32-bit head with only one entry holds instr_valid=0.
- Handshake: transfer when instr_valid && instr_ready. Pops 1 entry, or 2 if instr_is32. Outputs are stable while valid && !ready.
- Simultaneous push and pop in one cycle are both honoured; count = count + push - pop.
- Redirect (highest priority):
  - At the edge: queue flushed, any in-flight response marked discard, fetch_pc = redirect_pc.
  - Any handshake in the same cycle is ignored.
  - instr_valid=0 the next cycle; the first issue from redirect_pc is the cycle after redirect.
  - The discarded response never enters the queue.
  - Back-to-back redirects: the last one wins.
- Full queue: no issue. An in-flight read always has a free slot, guaranteed by the issue rule.
- rst asserted mid-stream: the same cycle's edge returns all state to reset values; the in-flight response is dropped.
- PC wrap inside a 32-bit pair: word2 comes from address 0.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the queue is empty and the arriving response is a non-32-bit word, it is driven straight to the outputs with instr_valid=1 in the same cycle. If accepted, it is not written into the queue. Cuts latency to 1 cycle after the issue.
- Not defined: all words pass through the queue; latency 2.

Test Plan:
- Reset release, FLASH[0]=16'h0FEF, instr_ready=1 -> instr_valid first high 2 cycles after first issue; instr_word1=16'hEF0F, instr_pc=0, instr_is32=0.
- FLASH[0]=16'h0C94, FLASH[1]=16'h3400 (jmp 0x34) -> one transfer with instr_is32=1, word1=16'h940C, word2=16'h0034; next instr_pc=2.
- instr_ready=0 for 10 cycles -> exactly DEPTH reads issued, flash_rd_en=0 afterwards, outputs stable; then ready=1 resumes issue.
- Redirect to 16'h0100 while the queue is full and a read is in flight -> stale data never appears; next valid has instr_pc=16'h0100.
- redirect_pc=2^ADDR_W-1 -> issues 3FFF then 0000; instr_pc sequence 3FFF, 0000.
- rst high for 1 cycle mid-stream with instr_valid=1 -> next cycle instr_valid=0 and flash_addr=0.
